// File: rtl/axis_pkg.sv
// axis_pkg: receive state encoding and default AXI-Stream width/depth shared by the FIFO slice
package axis_pkg;
  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_FIFO_DEPTH = 16;
  typedef enum logic {RX_IDLE = 1'b0, RX_FRAME = 1'b1} rx_state_t;
endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count
module axis_sync_fifo import axis_pkg::*; #(
  parameter int W = AXIS_DATA_W + 1,
  parameter int DEPTH = AXIS_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, do_wr, do_rd;
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  // Head word is presented combinationally; zero when empty so outputs are clean in reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];
  // Storage array, written without reset since occupancy alone qualifies the contents.
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;
  // Pointers wrap naturally at DEPTH; count tracks the net of writes and reads.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
endmodule

// File: rtl/axi_stream_slave_fifo.sv
// axi_stream_slave_fifo: AXI-Stream slave buffering words into a FWFT FIFO with frame tracking.
// Optional frame counter driving frame_avail is enabled by defining AXIS_SLAVE_FRAME_CNT_EN.
module axi_stream_slave_fifo import axis_pkg::*; #(
  parameter int C_S_AXIS_TDATA_WIDTH = AXIS_DATA_W,
  parameter int FIFO_DEPTH = AXIS_FIFO_DEPTH
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic                              s00_axis_tvalid,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready,
  input  logic                              rd_en,
  output logic                              rd_valid,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   rd_data,
  output logic                              rd_last,
  output logic                              strb_err,
  output logic                              frame_avail
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  logic [AW:0] count;
  logic empty, accept, pop;
  rx_state_t rx_state;
  // Ready is held low while reset is asserted and otherwise reflects free space only.
  assign s00_axis_tready = s00_axis_aresetn && (count < FULL_CNT);
  assign accept = s00_axis_tvalid && s00_axis_tready;
  assign rd_valid = !empty;
  assign pop = rd_en && rd_valid;
  axis_sync_fifo #(.W(C_S_AXIS_TDATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (s00_axis_aclk),
    .rst_n   (s00_axis_aresetn),
    .wr_en   (accept),
    .wr_data ({s00_axis_tlast, s00_axis_tdata}),
    .rd_en   (pop),
    .rd_data ({rd_last, rd_data}),
    .empty   (empty),
    .count   (count)
  );
  // Receive FSM: tracks whether the upstream is between frames or inside one.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn)
    if (!s00_axis_aresetn) rx_state <= RX_IDLE;
    else if (accept)
      case (rx_state)
        RX_IDLE:  rx_state <= s00_axis_tlast ? RX_IDLE : RX_FRAME;
        RX_FRAME: rx_state <= s00_axis_tlast ? RX_IDLE : RX_FRAME;
        default:  rx_state <= RX_IDLE;
      endcase
  // Sticky flag for any accepted word with partial byte qualifiers; the word is still kept.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn)
    if (!s00_axis_aresetn) strb_err <= 1'b0;
    else if (accept && !(&s00_axis_tstrb)) strb_err <= 1'b1;
`ifdef AXIS_SLAVE_FRAME_CNT_EN
  logic [AW:0] frame_cnt;
  logic frame_in, frame_out;
  assign frame_in = accept && s00_axis_tlast;
  assign frame_out = pop && rd_last;
  assign frame_avail = frame_cnt != '0;
  // Complete frames stored: up on an accepted tlast word, down on a popped tlast word.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn)
    if (!s00_axis_aresetn) frame_cnt <= '0;
    else frame_cnt <= frame_cnt + (AW+1)'(frame_in) - (AW+1)'(frame_out);
`else
  assign frame_avail = 1'b0;
`endif
endmodule
